// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared defaults, collision kind and pipeline tag for the dual-port SRAM arbiter.
// Contents: NUM_REQ/ADDR_W/DATA_W defaults, requester-id width, col_e, tag_t, rr_next().
package sram_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 7;
  localparam int DATA_W_DEF  = 32;
  localparam int ID_W        = 3;
  typedef enum logic {COL_NONE, COL_HIT} col_e;
  typedef struct packed {
    logic            valid;
    logic            we;
    logic [ID_W-1:0] id;
  } tag_t;
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: finds the first and second set bits of i_valid scanning upward from i_ptr with wrap.
// Ports: i_valid (request vector), i_ptr (start index),
//        o_f1/o_i1 (first winner found/index), o_f2/o_i2 (second winner found/index).
module rr_pick2
  import sram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    i_valid,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_f1,
  output logic [ID_W-1:0] o_i1,
  output logic            o_f2,
  output logic [ID_W-1:0] o_i2
);
  // Bit k of the rotated vector is requester (i_ptr + k) mod N.
  logic [2*N-1:0] w_dbl;
  int             w_j;
  assign w_dbl = {i_valid, i_valid} >> i_ptr;
  always_comb begin
    o_f1 = 1'b0;
    o_i1 = '0;
    o_f2 = 1'b0;
    o_i2 = '0;
    w_j  = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      w_j = (w_j >= N) ? w_j - N : w_j;
      if (w_dbl[k] && !o_f1) begin
        o_f1 = 1'b1;
        o_i1 = ID_W'(w_j);
      end else if (w_dbl[k] && !o_f2) begin
        o_f2 = 1'b1;
        o_i2 = ID_W'(w_j);
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter mapping NUM_REQ requesters onto a dual-port SRAM.
// Ports: clk_i/rstn_i (clock, async active-low reset); req_* (per-requester valid/ready/we/addr/wdata);
//        rsp_* (per-requester read valid pulse and data); sram_* (registered SRAM pins for ports 1/2,
//        CSB/WEB/OEB active low, sram_o*_i read data returned one cycle after the pins are presented).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [NUM_REQ*DATA_W-1:0] rsp_rdata_o,
  output logic [ADDR_W-1:0]         sram_a1_o,
  output logic [ADDR_W-1:0]         sram_a2_o,
  output logic [DATA_W-1:0]         sram_i1_o,
  output logic [DATA_W-1:0]         sram_i2_o,
  output logic                      sram_csb1_o,
  output logic                      sram_csb2_o,
  output logic                      sram_web1_o,
  output logic                      sram_web2_o,
  output logic                      sram_oeb1_o,
  output logic                      sram_oeb2_o,
  input  logic [DATA_W-1:0]         sram_o1_i,
  input  logic [DATA_W-1:0]         sram_o2_i
);
  logic              r_en;
  logic [ID_W-1:0]   r_rr;
  tag_t [1:0]        r_t1;
  tag_t [1:0]        r_t2;
  logic [DATA_W-1:0] r_rd [NUM_REQ];
  logic              w_f1, w_f2, w_g1, w_g2, w_we1, w_we2;
  logic [ID_W-1:0]   w_i1, w_i2;
  logic [ADDR_W-1:0] w_a1, w_a2;
  logic [DATA_W-1:0] w_d1, w_d2;
  logic [NUM_REQ-1:0] w_h1, w_h2;
  col_e              w_col;
  rr_pick2 #(.N(NUM_REQ)) u_pick (
    .i_valid(req_valid_i),
    .i_ptr  (r_rr),
    .o_f1   (w_f1),
    .o_i1   (w_i1),
    .o_f2   (w_f2),
    .o_i2   (w_i2)
  );
  assign w_we1 = req_we_i[w_i1];
  assign w_we2 = req_we_i[w_i2];
  assign w_a1  = req_addr_i[w_i1*ADDR_W +: ADDR_W];
  assign w_a2  = req_addr_i[w_i2*ADDR_W +: ADDR_W];
  assign w_d1  = req_wdata_i[w_i1*DATA_W +: DATA_W];
  assign w_d2  = req_wdata_i[w_i2*DATA_W +: DATA_W];
  // Same word touched by both ports with a write involved: only the first winner proceeds.
  assign w_col = (w_f2 && w_a1 == w_a2 && (w_we1 || w_we2)) ? COL_HIT : COL_NONE;
  // r_en is low for the first cycle after reset release, suppressing grants.
  assign w_g1  = r_en && w_f1;
  assign w_g2  = r_en && w_f2 && w_col == COL_NONE;
  assign sram_oeb1_o = ~rstn_i;
  assign sram_oeb2_o = ~rstn_i;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_ready_o[g] = (w_g1 && w_i1 == ID_W'(g)) || (w_g2 && w_i2 == ID_W'(g));
    assign w_h1[g] = r_t2[0].valid && !r_t2[0].we && r_t2[0].id == ID_W'(g);
    assign w_h2[g] = r_t2[1].valid && !r_t2[1].we && r_t2[1].id == ID_W'(g);
    assign rsp_valid_o[g] = w_h1[g] || w_h2[g];
    // Live SRAM data while responding, otherwise the last delivered word.
    assign rsp_rdata_o[g*DATA_W +: DATA_W] = w_h1[g] ? sram_o1_i : w_h2[g] ? sram_o2_i : r_rd[g];
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_en        <= 1'b0;
      r_rr        <= '0;
      sram_csb1_o <= 1'b1;
      sram_csb2_o <= 1'b1;
      sram_web1_o <= 1'b1;
      sram_web2_o <= 1'b1;
      sram_a1_o   <= '0;
      sram_a2_o   <= '0;
      sram_i1_o   <= '0;
      sram_i2_o   <= '0;
      r_t1        <= '0;
      r_t2        <= '0;
      for (int k = 0; k < NUM_REQ; k++) r_rd[k] <= '0;
    end else begin
      r_en        <= 1'b1;
      if (w_g1) r_rr <= rr_next(w_g2 ? w_i2 : w_i1, NUM_REQ);
      sram_csb1_o <= ~w_g1;
      sram_csb2_o <= ~w_g2;
      sram_web1_o <= ~(w_g1 && w_we1);
      sram_web2_o <= ~(w_g2 && w_we2);
      if (w_g1) begin
        sram_a1_o <= w_a1;
        sram_i1_o <= w_d1;
      end
      if (w_g2) begin
        sram_a2_o <= w_a2;
        sram_i2_o <= w_d2;
      end
      r_t1[0] <= '{valid: w_g1, we: w_we1, id: w_i1};
      r_t1[1] <= '{valid: w_g2, we: w_we2, id: w_i2};
      r_t2    <= r_t1;
      for (int k = 0; k < NUM_REQ; k++)
        if (w_h1[k]) r_rd[k] <= sram_o1_i;
        else if (w_h2[k]) r_rd[k] <= sram_o2_i;
    end
  end
endmodule
